// File: rtl/ws2812_frame_sequencer.sv
// WS2812 frame sequencer: steps the upstream GRB shift register through one colour word per LED
// and turns its MSB into the one-wire NRZ waveform, followed by a latch low period, forever.
module ws2812_frame_sequencer #(
  parameter int NUM_LEDS     = 8,
  parameter int BIT_CYCLES   = 125,
  parameter int T0H_CYCLES   = 40,
  parameter int T1H_CYCLES   = 80,
  parameter int RESET_CYCLES = 6000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CurrentBit,
  output logic       LoadRegister,
  output logic       RotateRegisterLeft,
  output logic [3:0] LEDCount,
  output logic       DataOut,
  output logic       FrameDone
);

  localparam int CNT_MAX = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] LATCH_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [3:0]    LED_LAST   = 4'(NUM_LEDS - 1);
  localparam logic [4:0]    BIT_22     = 5'd22;
  localparam logic [4:0]    BIT_23     = 5'd23;

  typedef enum logic {
    ST_LATCH = 1'b0,
    ST_SEND  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [3:0]    led_q, led_d;
  logic          last_q, last_d;
  logic          load_q, load_d;
  logic          rot_q, rot_d;
  logic          done_q, done_d;
  logic          dout_q, dout_d;

  // Next-state logic; control pulses are decoded from the next state so they leave a register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    bit_d   = bit_q;
    led_d   = led_q;
    last_d  = last_q;
    dout_d  = 1'b0;
    case (state_q)
      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = ST_SEND;
          cnt_d   = '0;
          bit_d   = 5'd0;
          led_d   = 4'd0;
        end else begin
          state_d = ST_LATCH;
        end
      end
      ST_SEND: begin
        dout_d = CurrentBit ? (int'(cnt_q) < T1H_CYCLES) : (int'(cnt_q) < T0H_CYCLES);
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_23) begin
            bit_d = 5'd0;
            if (last_q) begin
              state_d = ST_LATCH;
              led_d   = 4'd0;
            end else begin
              state_d = ST_SEND;
            end
          end else begin
            bit_d = bit_q + 5'd1;
            // LEDCount moves ahead during bit 23 so it is already valid for the next load;
            // last_d remembers whether this word was the final one of the frame.
            if (bit_q == BIT_22) begin
              if (led_q < LED_LAST) begin
                led_d  = led_q + 4'd1;
                last_d = 1'b0;
              end else begin
                last_d = 1'b1;
              end
            end else begin
              last_d = last_q;
            end
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_LATCH;
        cnt_d   = '0;
      end
    endcase

    load_d = ((state_d == ST_LATCH) && (cnt_d == LATCH_LAST)) ||
             ((state_d == ST_SEND) && (cnt_d == BIT_LAST) && (bit_d == BIT_23) && !last_d);
    rot_d  = (state_d == ST_SEND) && (cnt_d == BIT_LAST) && (bit_d != BIT_23);
    done_d = (state_d == ST_SEND) && (cnt_d == BIT_LAST) && (bit_d == BIT_23) && last_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LATCH;
      cnt_q   <= '0;
      bit_q   <= 5'd0;
      led_q   <= 4'd0;
      last_q  <= 1'b0;
      load_q  <= 1'b0;
      rot_q   <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      last_q  <= last_d;
      load_q  <= load_d;
      rot_q   <= rot_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  assign LoadRegister       = load_q;
  assign RotateRegisterLeft = rot_q;
  assign LEDCount           = led_q;
  assign DataOut            = dout_q;
  assign FrameDone          = done_q;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Bench for ws2812_frame_sequencer: four instances with different parameter sets, each fed by a
// behavioural shift-register model and checked against a frame-position reference model.
module tb_ws2812_frame_sequencer;

  logic        clk  = 1'b0;
  logic [3:0]  rst  = 4'hF;
  logic [3:0]  cbit = 4'h0;
  logic [3:0]  load, rot, dout, done;
  logic [3:0]  ledc [4];
  logic [23:0] base [4];
  logic [23:0] word [4];

  logic        s_load = 1'b0, s_rot = 1'b0, s_dout = 1'b0, s_done = 1'b0;
  logic [3:0]  s_led = 4'd0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ws2812_frame_sequencer #(.NUM_LEDS(8)) dut0 (
    .clk(clk), .reset(rst[0]), .CurrentBit(cbit[0]), .LoadRegister(load[0]),
    .RotateRegisterLeft(rot[0]), .LEDCount(ledc[0]), .DataOut(dout[0]), .FrameDone(done[0]));
  ws2812_frame_sequencer #(.NUM_LEDS(3)) dut1 (
    .clk(clk), .reset(rst[1]), .CurrentBit(cbit[1]), .LoadRegister(load[1]),
    .RotateRegisterLeft(rot[1]), .LEDCount(ledc[1]), .DataOut(dout[1]), .FrameDone(done[1]));
  ws2812_frame_sequencer #(.NUM_LEDS(4)) dut2 (
    .clk(clk), .reset(rst[2]), .CurrentBit(cbit[2]), .LoadRegister(load[2]),
    .RotateRegisterLeft(rot[2]), .LEDCount(ledc[2]), .DataOut(dout[2]), .FrameDone(done[2]));
  ws2812_frame_sequencer #(.NUM_LEDS(1), .BIT_CYCLES(10), .T0H_CYCLES(3), .T1H_CYCLES(7),
                           .RESET_CYCLES(20)) dut3 (
    .clk(clk), .reset(rst[3]), .CurrentBit(cbit[3]), .LoadRegister(load[3]),
    .RotateRegisterLeft(rot[3]), .LEDCount(ledc[3]), .DataOut(dout[3]), .FrameDone(done[3]));

  function automatic int p_n(input int k);
    case (k)
      0: return 8;
      1: return 3;
      2: return 4;
      default: return 1;
    endcase
  endfunction
  function automatic int p_b(input int k);   return (k == 3) ? 10 : 125;  endfunction
  function automatic int p_t0(input int k);  return (k == 3) ? 3 : 40;    endfunction
  function automatic int p_t1(input int k);  return (k == 3) ? 7 : 80;    endfunction
  function automatic int p_r(input int k);   return (k == 3) ? 20 : 6000; endfunction
  function automatic int p_len(input int k); return p_n(k) * 24 * p_b(k) + p_r(k); endfunction

  // Reference: cycle c counts from the first cycle with reset low; a frame is a latch period of
  // R cycles then N*24 back-to-back bits, LED i carrying base+i MSB first, DataOut one cycle late.
  function automatic logic [7:0] exp_vec(input int k, input int c);
    int p, s, j, led, fb;
    logic [23:0] w;
    logic e_dout, e_load, e_rot, e_done;
    p = c % p_len(k);
    fb = 24 * p_b(k);
    e_dout = 1'b0;
    e_rot = 1'b0;
    e_load = (p == p_r(k) - 1);
    e_done = (p == p_len(k) - 1);
    led = 0;
    s = p - 1 - p_r(k);
    if (s >= 0) begin
      j = s / p_b(k);
      w = base[k] + 24'(j / 24);
      e_dout = (s % p_b(k)) < (w[23 - (j % 24)] ? p_t1(k) : p_t0(k));
    end
    s = p - p_r(k);
    if (s >= 0) begin
      j = s / p_b(k);
      led = j / 24;
      e_load = ((s % fb) == fb - 1) && (led < p_n(k) - 1);
      e_rot = ((s % p_b(k)) == p_b(k) - 1) && ((j % 24) != 23);
      if ((j % 24) == 23 && led < p_n(k) - 1) led = led + 1;
    end
    return {e_dout, e_load, e_rot, e_done, 4'(led)};
  endfunction

  function automatic logic [7:0] obs();
    return {s_dout, s_load, s_rot, s_done, s_led};
  endfunction

  // One clock: apply the shift-register reaction to last cycle's pulses, then sample mid-cycle.
  task automatic step(input int k, input logic r);
    @(posedge clk);
    #1;
    rst[k] = r;
    if (s_load) word[k] = base[k] + {20'd0, s_led};
    else if (s_rot) word[k] = {word[k][22:0], word[k][23]};
    cbit[k] = word[k][23];
    @(negedge clk);
    s_load = load[k];
    s_rot  = rot[k];
    s_dout = dout[k];
    s_done = done[k];
    s_led  = ledc[k];
    cyc    = cyc + 1;
  endtask

  task automatic start(input int k);
    s_load = 1'b0;
    s_rot  = 1'b0;
    word[k] = 24'h000000;
    for (int i = 0; i < 3; i++) step(k, 1'b1);
    cyc = -1;
  endtask

  task automatic test_reset();
    int bad, first, nload, load_at, load_led, early_hi;
    logic [7:0] got, want;
    base[0] = 24'hFF0000;
    start(0);
    n_tests++;
    if (obs() !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: outputs %h, required 00", obs());
    end
    bad = 0; first = -1; nload = 0; load_at = -1; load_led = -1; early_hi = 0;
    got = 8'h00; want = 8'h00;
    for (int i = 0; i <= p_r(0) + 1; i++) begin
      step(0, 1'b0);
      if (obs() !== exp_vec(0, cyc)) begin
        if (bad == 0) begin first = cyc; got = obs(); want = exp_vec(0, cyc); end
        bad++;
      end
      if (s_load === 1'b1) begin nload++; load_at = cyc; load_led = int'(s_led); end
      if (cyc <= p_r(0) && s_dout !== 1'b0) early_hi++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL latch_window: %0d bad cycles, first at %0d got %h required %h", bad, first, got, want);
    end
    n_tests++;
    if (early_hi !== 0) begin
      n_fail++;
      $display("FAIL latch_low: DataOut high on %0d latch cycles, required 0", early_hi);
    end
    n_tests++;
    if (nload !== 1 || load_at !== 5999 || load_led !== 0) begin
      n_fail++;
      $display("FAIL latch_load: %0d loads, last at %0d led %0d, required 1 at 5999 led 0", nload, load_at, load_led);
    end
    n_tests++;
    if (s_dout !== 1'b1) begin
      n_fail++;
      $display("FAIL first_rise: DataOut %b two cycles after load, required 1", s_dout);
    end
  endtask

  task automatic test_bit_encoding();
    int hi [24];
    int bad, j, m;
    for (int i = 0; i < 24; i++) hi[i] = 0;
    hi[0] = (s_dout === 1'b1) ? 1 : 0;
    bad = 0;
    for (int i = 0; i < 24 * p_b(0) - 1; i++) begin
      step(0, 1'b0);
      j = (cyc - p_r(0) - 1) / p_b(0);
      m = (cyc - p_r(0) - 1) % p_b(0);
      if (s_dout === 1'b1) hi[j]++;
      if (s_dout !== ((m < ((j < 8) ? 80 : 40)) ? 1'b1 : 1'b0)) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bit_shape: %0d cycles off the FF0000 waveform, required 0", bad);
    end
    for (int b = 0; b < 24; b++) begin
      n_tests++;
      if (hi[b] !== ((b < 8) ? 80 : 40)) begin
        n_fail++;
        $display("FAIL bit_high_time: bit %0d high %0d cycles, required %0d", b, hi[b], (b < 8) ? 80 : 40);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    int bad, target, nload, load_at, load_led;
    target = p_r(0) + 34 * p_b(0) + 50;
    bad = 0;
    while (cyc < target) begin
      step(0, 1'b0);
      if (obs() !== exp_vec(0, cyc)) bad++;
    end
    n_tests++;
    if (bad !== 0 || s_led !== 4'd1) begin
      n_fail++;
      $display("FAIL pre_reset: %0d bad cycles, LEDCount %0d, required 0 bad and LEDCount 1", bad, s_led);
    end
    step(0, 1'b1);
    cyc = -1;
    step(0, 1'b0);
    n_tests++;
    if (obs() !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_clear: outputs %h, required 00", obs());
    end
    bad = 0; nload = 0; load_at = -1; load_led = -1;
    for (int i = 1; i <= p_r(0) + 1; i++) begin
      step(0, 1'b0);
      if (obs() !== exp_vec(0, cyc)) bad++;
      if (s_load === 1'b1) begin nload++; load_at = cyc; load_led = int'(s_led); end
    end
    n_tests++;
    if (bad !== 0 || nload !== 1 || load_at !== 5999 || load_led !== 0 || s_dout !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_relatch: bad %0d, loads %0d at %0d led %0d, rise %b, required 0,1,5999,0,1", bad, nload, load_at, load_led, s_dout);
    end
  endtask

  task automatic test_pulse_counts();
    int leds[$];
    int bad, nrot, ndone, done_at, both;
    base[1] = 24'($urandom);
    start(1);
    bad = 0; nrot = 0; ndone = 0; done_at = -1; both = 0;
    for (int i = 0; i <= p_len(1); i++) begin
      step(1, 1'b0);
      if (obs() !== exp_vec(1, cyc)) bad++;
      if (s_load === 1'b1) leds.push_back(int'(s_led));
      if (s_rot === 1'b1) nrot++;
      if (s_done === 1'b1) begin ndone++; done_at = cyc; end
      if (s_load === 1'b1 && s_rot === 1'b1) both++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL frame3_trace: %0d bad cycles, required 0", bad);
    end
    n_tests++;
    if (leds.size() !== 3) begin
      n_fail++;
      $display("FAIL load_count: %0d loads, required 3", leds.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (i >= leds.size() || leds[i] !== i) begin
        n_fail++;
        $display("FAIL load_led: load %0d LEDCount missing or wrong, required %0d", i, i);
      end
    end
    n_tests++;
    if (nrot !== 69 || ndone !== 1 || both !== 0) begin
      n_fail++;
      $display("FAIL pulse_counts: rot %0d done %0d overlap %0d, required 69 1 0", nrot, ndone, both);
    end
    n_tests++;
    if (done_at + 1 !== 15000) begin
      n_fail++;
      $display("FAIL frame_length: %0d cycles, required 15000", done_at + 1);
    end
  endtask

  task automatic test_per_led_colour();
    int hi [96];
    int bad, j;
    logic [23:0] dec;
    base[2] = 24'($urandom);
    start(2);
    for (int i = 0; i < 96; i++) hi[i] = 0;
    bad = 0;
    for (int i = 0; i <= p_len(2); i++) begin
      step(2, 1'b0);
      if (obs() !== exp_vec(2, cyc)) bad++;
      if (cyc >= p_r(2) + 1 && cyc <= p_r(2) + 96 * p_b(2)) begin
        j = (cyc - p_r(2) - 1) / p_b(2);
        if (s_dout === 1'b1) hi[j]++;
      end
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL frame4_trace: %0d bad cycles, required 0", bad);
    end
    for (int l = 0; l < 4; l++) begin
      for (int b = 0; b < 24; b++) dec[23 - b] = (hi[l * 24 + b] > 60);
      n_tests++;
      if (dec !== base[2] + 24'(l)) begin
        n_fail++;
        $display("FAIL led_colour: LED %0d decoded %h, required %h", l, dec, base[2] + 24'(l));
      end
    end
  endtask

  task automatic test_single_led();
    int bad, ndone, misplaced, led_nz;
    base[3] = 24'($urandom);
    start(3);
    bad = 0; ndone = 0; misplaced = 0; led_nz = 0;
    for (int i = 0; i < 3 * 260; i++) begin
      step(3, 1'b0);
      if (obs() !== exp_vec(3, cyc)) bad++;
      if (s_done === 1'b1) begin
        ndone++;
        if (cyc % 260 != 259) misplaced++;
      end
      if (s_led !== 4'd0) led_nz++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL single_trace: %0d bad cycles, required 0", bad);
    end
    n_tests++;
    if (ndone !== 3 || misplaced !== 0) begin
      n_fail++;
      $display("FAIL single_done: %0d pulses, %0d off the 260-cycle grid, required 3 and 0", ndone, misplaced);
    end
    n_tests++;
    if (led_nz !== 0) begin
      n_fail++;
      $display("FAIL single_ledcount: nonzero on %0d cycles, required 0", led_nz);
    end
  endtask

  initial begin
    test_reset();
    test_bit_encoding();
    test_mid_frame_reset();
    test_pulse_counts();
    test_per_led_colour();
    test_single_led();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
- Drives the WS2812 LED chain: converts the serial CurrentBit stream from the upstream 24-bit GRB shift register into the one-wire NRZ waveform.
- Generates the shift register's LoadRegister, RotateRegisterLeft and LEDCount controls, so each LED in the chain is loaded with its own colour word.
- Each frame is NUM_LEDS × 24 bits followed by a latch/reset low period, repeated forever.
- Sits between the shift register and the top-level pin DataOut; 100 MHz clk.

Parameters:
- NUM_LEDS, 8, LEDs per frame; legal range 1..16.
- BIT_CYCLES, 125, clk cycles per data bit (1.25 us).
- T0H_CYCLES, 40, high time for a 0 bit (0.40 us).
- T1H_CYCLES, 80, high time for a 1 bit (0.80 us).
- RESET_CYCLES, 6000, latch low time between frames (60 us, at least 50 us).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- CurrentBit  in  1  MSB of the shift register, registered upstream.
- LoadRegister  out  1  one-cycle pulse; the shift register loads a new colour word on the next edge.
- RotateRegisterLeft  out  1  one-cycle pulse; the shift register rotates left by 1 on the next edge.
- LEDCount  out  4  index of the LED being sent; sampled by the shift register only while LoadRegister=1.
- DataOut  out  1  registered WS2812 serial data pin.
- FrameDone  out  1  one-cycle pulse on the last cycle of the last bit of a frame.

Behaviour:
- Reset (clk, reset: synchronous, active-high):
  - State goes to LATCH with cycle counter 0, bit index 0 and LEDCount 0.
  - DataOut=0, LoadRegister=0, RotateRegisterLeft=0, FrameDone=0.
  - Reset mid-frame aborts the frame. A full RESET_CYCLES low period always precedes the next frame.
- State LATCH:
  - DataOut is held 0 and the counter counts 0..RESET_CYCLES-1.
  - On the cycle with count==RESET_CYCLES-1: LoadRegister=1 and LEDCount=0; next state SEND, counter 0, bit index 0.
- State SEND, per bit:
  - The counter counts 0..BIT_CYCLES-1.
  - Each cycle, DataOut is registered from (count < (CurrentBit ? T1H_CYCLES : T0H_CYCLES)).
  - DataOut therefore lags the counter by exactly 1 cycle. The first DataOut rise of a frame occurs 2 cycles after the LoadRegister pulse cycle.
- End of a bit (count==BIT_CYCLES-1):
  - Bit index < 23: RotateRegisterLeft=1; bit index increments; counter returns to 0.
  - Bit index == 23 and LEDCount < NUM_LEDS-1: LoadRegister=1 (not Rotate); bit index 0; counter 0.
  - Bit index == 23 and LEDCount == NUM_LEDS-1: FrameDone=1; no Load or Rotate; next state LATCH, counter 0, LEDCount cleared to 0.
- LEDCount update:
  - Increments on the edge where bit index goes 22→23, only if LEDCount < NUM_LEDS-1.
  - This keeps LEDCount stable and correct during the following LoadRegister cycle.
  - LEDCount never exceeds NUM_LEDS-1.
- Control pulse rules:
  - LoadRegister and RotateRegisterLeft are never high in the same cycle.
  - Both are exactly one cycle wide.
  - Per frame: exactly NUM_LEDS Load pulses (1 from LATCH, NUM_LEDS-1 from SEND) and NUM_LEDS×23 Rotate pulses.
- Frame length: NUM_LEDS×24×BIT_CYCLES + RESET_CYCLES cycles, with no gaps between bits.
- NUM_LEDS=1: no LEDCount increment; after bit 23, go directly to LATCH.
- CurrentBit is only meaningful to the block in SEND. A CurrentBit change mid-bit alters only the comparison threshold.
- Upstream never changes CurrentBit except after Load or Rotate edges, so the bench may assume this.
- Counter widths must hold RESET_CYCLES-1 and BIT_CYCLES-1 without overflow.

Test Plan:
1. Reset and latch:
   - Stimulus: defaults; hold reset 3 cycles, release.
   - Required: DataOut=0 for 6000 cycles; a single LoadRegister pulse with LEDCount=0 on cycle 5999 after release; DataOut rises 2 cycles later.
2. Bit encoding:
   - Stimulus: shift register model loaded with 24'hFF0000.
   - Required: first 8 bits high for 80 cycles and low for 45; remaining 16 bits high for 40 and low for 85; each period exactly 125 cycles.
3. Pulse counts:
   - Stimulus: NUM_LEDS=3 over one frame.
   - Required: 3 Load pulses with LEDCount 0, 1, 2; 69 Rotate pulses; 1 FrameDone; frame length 3×24×125+6000=15000 cycles; Load and Rotate never simultaneously high.
4. Per-LED colour:
   - Stimulus: model adds LEDCount to its word; NUM_LEDS=4.
   - Required: decoded DataOut words differ per LED exactly as the model's loads.
5. Mid-frame reset:
   - Stimulus: assert reset at LED 1, bit 10.
   - Required: next cycle all outputs 0; full 6000-cycle low period; new frame starts with LEDCount=0.
6. Single-LED frame:
   - Stimulus: NUM_LEDS=1; BIT_CYCLES=10, T0H_CYCLES=3, T1H_CYCLES=7, RESET_CYCLES=20.
   - Required: 24-bit bursts separated by 20-cycle lows; FrameDone every 260 cycles; LEDCount stays 0.
